// File: rtl/demux_pkg.sv
// Shared types and constants for the four-channel demux router.
package demux_pkg;

   typedef logic [1:0] chan_sel_t;

   localparam int NUM_CH        = 4;
   localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register; a load in the same cycle as a drain
// leaves the slot full with the new word.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // NOTE: sequential state is written only with <= so every register samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         // NOTE: the data register is cleared too, so consumers see zero rather
         // than X after reset; after a drain it deliberately keeps its value.
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux4_router.sv
// Routes one word per cycle to one of four buffered valid/ready channels.
// Optional per-channel saturating accept counters when DEMUX_STATS_EN is defined.
module demux4_router
   import demux_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       y_valid,
   input  logic [3:0]       y_ready,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3
`ifdef DEMUX_STATS_EN
   ,
   output logic [4*CNT_W-1:0] stat_cnt
`endif
);

   chan_sel_t         sel;
   logic              accept;
   logic [NUM_CH-1:0] load;
   logic [WIDTH-1:0]  slot_data [NUM_CH];

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   assign sel = chan_sel_t'(in_sel);

   // A full slot that is draining this cycle can take the next word.
   assign in_ready = !reset && (!y_valid[sel] || y_ready[sel]);
   assign accept   = in_valid && in_ready;

   always_comb begin
      load = '0;
      if (accept) load[sel] = 1'b1;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load      (load[k]),
         .load_data (in_data),
         .ready     (y_ready[k]),
         .valid     (y_valid[k]),
         .data      (slot_data[k])
      );
   end

   assign y0 = slot_data[0];
   assign y1 = slot_data[1];
   assign y2 = slot_data[2];
   assign y3 = slot_data[3];

`ifdef DEMUX_STATS_EN
   logic [CNT_W-1:0] cnt [NUM_CH];

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (reset) begin
            cnt[k] <= '0;
         end else if (load[k] && (cnt[k] != {CNT_W{1'b1}})) begin
            cnt[k] <= cnt[k] + CNT_W'(1);
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
      assign stat_cnt[k*CNT_W +: CNT_W] = cnt[k];
   end
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Scoreboard bench for demux4_router: per-channel expected-word queues filled by
// the driver, checked by an independent monitor on the falling edge.
module tb_demux4_router;

   localparam int WIDTH = 4;
`ifdef DEMUX_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 8;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_sel = 2'd0;
   logic [WIDTH-1:0] in_data = '0;
   logic [3:0]       y_valid;
   logic [3:0]       y_ready = 4'b0000;
   logic [WIDTH-1:0] y0, y1, y2, y3;
`ifdef DEMUX_STATS_EN
   logic [4*CNT_W-1:0] stat_cnt;
`endif

   int errors = 0;
   int checks = 0;
   bit run_mon = 1'b0;

   // Reference model: words accepted but not yet taken, per channel, plus accept counts.
   logic [WIDTH-1:0] q [4][$];
   int               acc_cnt [4];

   always #5 clk = ~clk;

   demux4_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y0       (y0),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3)
`ifdef DEMUX_STATS_EN
      ,
      .stat_cnt (stat_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares handshake and slot contents against the queues, pops on delivery.
   always @(negedge clk) begin
      if (run_mon) begin
         logic [WIDTH-1:0] yv [4];
         bit               exp_ready;
         yv = '{y0, y1, y2, y3};
         exp_ready = !reset && ((q[in_sel].size() == 0) || y_ready[in_sel]);
         check("in_ready", 32'(in_ready), 32'(exp_ready));
         for (int k = 0; k < 4; k++) begin
            check($sformatf("y_valid[%0d]", k), 32'(y_valid[k]), 32'(q[k].size() != 0));
            if (q[k].size() != 0) begin
               check($sformatf("y%0d_data", k), 32'(yv[k]), 32'(q[k][0]));
               if (y_ready[k]) void'(q[k].pop_front());
            end
         end
      end
   end

   // Driver: one clock per call; records the expected acceptance after the monitor has run.
   task automatic cycle(input bit r, input bit v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] rdy);
      @(posedge clk);
      #1;
      reset    = r;
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      y_ready  = rdy;
      @(negedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < 4; k++) begin
            q[k].delete();
            acc_cnt[k] = 0;
         end
      end else if (v && ((q[s].size() == 0) || rdy[s])) begin
         q[s].push_back(d);
         acc_cnt[s]++;
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef DEMUX_STATS_EN
      int sat;
      sat = (1 << CNT_W) - 1;
      for (int k = 0; k < 4; k++) begin
         logic [CNT_W-1:0] got;
         int               want;
         got  = stat_cnt[k*CNT_W +: CNT_W];
         want = (acc_cnt[k] > sat) ? sat : acc_cnt[k];
         check($sformatf("%s stat_cnt[%0d]", tag, k), 32'(got), 32'(want));
      end
`else
      check($sformatf("%s no_stats y_valid_width", tag), 32'($bits(y_valid)), 32'd4);
`endif
   endtask

   initial begin
      // Reset held two cycles with a word offered: nothing may be accepted.
      cycle(1'b1, 1'b1, 2'd2, 4'hF, 4'b0000);
      run_mon = 1'b1;
      cycle(1'b1, 1'b1, 2'd2, 4'hF, 4'b0000);
      check("reset y0", 32'(y0), 32'h0);
      check("reset y1", 32'(y1), 32'h0);
      check("reset y2", 32'(y2), 32'h0);
      check("reset y3", 32'(y3), 32'h0);
      check("reset y_valid", 32'(y_valid), 32'h0);
      check_stats("reset");

      // Basic routing to each channel on consecutive cycles.
      cycle(1'b0, 1'b1, 2'd0, 4'hA, 4'b1111);
      cycle(1'b0, 1'b1, 2'd1, 4'h5, 4'b1111);
      check("route y_valid after sel0", 32'(y_valid), 32'h1);
      cycle(1'b0, 1'b1, 2'd2, 4'hC, 4'b1111);
      check("route y_valid after sel1", 32'(y_valid), 32'h2);
      cycle(1'b0, 1'b1, 2'd3, 4'h3, 4'b1111);
      check("route y_valid after sel2", 32'(y_valid), 32'h4);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);
      check("route y_valid after sel3", 32'(y_valid), 32'h8);
      check("route y3", 32'(y3), 32'h3);

      // Backpressure on channel 2 while channel 0 keeps flowing.
      cycle(1'b0, 1'b1, 2'd2, 4'h7, 4'b1011);
      cycle(1'b0, 1'b1, 2'd2, 4'h9, 4'b1011);
      check("bp in_ready blocked", 32'(in_ready), 32'h0);
      cycle(1'b0, 1'b1, 2'd0, 4'h1, 4'b1011);
      check("bp y2 held", 32'(y2), 32'h7);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1011);
      check("bp y0 delivered", 32'(y0), 32'h1);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);

      // Simultaneous load and drain on channel 1.
      cycle(1'b0, 1'b1, 2'd1, 4'h4, 4'b0000);
      cycle(1'b0, 1'b1, 2'd1, 4'hE, 4'b0010);
      check("sld in_ready", 32'(in_ready), 32'h1);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000);
      check("sld y1", 32'(y1), 32'hE);
      check("sld y_valid[1]", 32'(y_valid[1]), 32'h1);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);

      // Reset mid-traffic discards buffered words.
      cycle(1'b0, 1'b1, 2'd0, 4'h6, 4'b0000);
      cycle(1'b0, 1'b1, 2'd3, 4'hB, 4'b0000);
      cycle(1'b1, 1'b1, 2'd1, 4'h2, 4'b1111);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);
      check("midreset y_valid", 32'(y_valid), 32'h0);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);

      // Five words to channel 1 exercise counter saturation.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd1, 4'(i + 1), 4'b1111);
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);
      check_stats("sat");

      // Randomized traffic with random backpressure and occasional reset.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
               2'($urandom), WIDTH'($urandom), 4'($urandom));
      end
      cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);
      check_stats("random");

      run_mon = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux4_router.md
Name: demux4_router

Overview:
- Inverse of the 4:1 select path: routes one WIDTH-bit input word to one of four output channels, chosen by a 2-bit select.
- Each channel has a one-entry registered holding slot with valid/ready handshake, so a stalled channel does not block traffic to the others.
- Sits downstream of a producer that tags each word with a destination index. It feeds four independent consumers.

Parameters:
- WIDTH, 4, data word width in bits.
- CNT_W, 8, width of each per-channel statistics counter (used only with DEMUX_STATS_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  router accepts the word this cycle.
- in_sel  input  2  destination channel index, 0..3.
- in_data  input  WIDTH  word to route.
- y_valid  output  4  bit k: slot k holds a word.
- y_ready  input  4  bit k: consumer k takes slot k's word this cycle.
- y0, y1, y2, y3  output  WIDTH each  slot data for channels 0..3.
- stat_cnt  output  4*CNT_W  per-channel accept counters, channel k in bits [k*CNT_W +: CNT_W]; present only with DEMUX_STATS_EN.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset state: y_valid = 4'b0000, y0..y3 = 0, stat_cnt = 0, and in_ready forced to 0 while reset is high.
- Accept condition: a word is accepted when in_valid and in_ready are both high.
- in_ready (combinational, reset low): in_ready = !y_valid[in_sel] || y_ready[in_sel]. A full slot being drained in the same cycle can be refilled.
- Drain condition: a word leaves slot k when y_valid[k] and y_ready[k] are both high.
- Slot k update on rising edge, in priority order:
  - reset: clear.
  - accept with in_sel == k: load in_data into yk and set y_valid[k], whether or not a drain also occurs (simultaneous load and drain leaves the slot full with the new word).
  - drain only: clear y_valid[k].
  - otherwise: hold.
- Latency: accepted word appears on yk with y_valid[k] = 1 one cycle after acceptance.
- Throughput: 1 word/cycle sustained to a single channel when its consumer holds y_ready high.
- Output data retention:
  - yk is stable while y_valid[k] is high and y_ready[k] is low.
  - yk keeps its last value after being drained; it is not zeroed.
- Independence: slots not selected by in_sel ignore in_data and change only by draining. Four consumers may drain in the same cycle.
- No internal state machine beyond per-slot full flags. At most one slot is loaded per cycle.
- Reset mid-operation: buffered words are discarded and no handshake completes in the reset cycle.
- The router never drops, duplicates or reorders words within a channel.
- in_sel and in_data are don't-care when in_valid is low.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - stat_cnt port exists.
  - Counter k increments by 1 on each accept with in_sel == k and saturates at 2^CNT_W-1 (no wrap).
  - Counters are cleared only by reset.
- Undefined: stat_cnt port and counter logic are absent; routing behaviour is identical.

Decomposition:
- Package demux_pkg:
  - typedef chan_sel_t (2-bit logic).
  - localparam NUM_CH = 4.
  - default CNT_W.
- Sub-module demux_slot: one-entry valid/ready holding register.
  - Ports: clk, reset, load, load_data, ready, valid, data.
  - Instantiated four times. The top level contains the in_ready mux, load decode, and optional counters.

Test Plan:
- Reset: hold reset 2 cycles with in_valid = 1 -> in_ready = 0, y_valid = 0000, y0..y3 = 0, and no word is accepted.
- Basic routing: y_ready = 1111; send sel 0,1,2,3 with data 4'hA, 4'h5, 4'hC, 4'h3 on consecutive cycles -> each word appears on y0..y3 respectively one cycle later; y_valid pulses 0001, 0010, 0100, 1000.
- Backpressure: y_ready[2] = 0; send 4'h7 to ch2 -> slot fills. Then send 4'h9 to ch2 -> in_ready = 0 and y2 stays 4'h7. In the same cycles, send 4'h1 to ch0 -> accepted.
- Simultaneous load/drain: slot 1 full with 4'h4, y_ready[1] = 1, in_sel = 1, in_data = 4'hE -> in_ready = 1; next cycle y1 = 4'hE with y_valid[1] still 1.
- Reset mid-traffic: fill slots 0 and 3, then assert reset for 1 cycle -> y_valid = 0000 and no stale word is delivered afterwards.
- DEMUX_STATS_EN with CNT_W = 2: send 5 words to ch1 with y_ready = 1111 -> stat_cnt channel 1 = 3 (saturated), other channels 0.
